spi_op_master: RTL
==================

# spi_op_master

SPI master front-end for the SPI-attached functional units (shifter, ALU slaves) of the single-cycle processor. Accepts an operation (4-bit opcode, 32-bit operands A and B) over a valid/ready command port and serializes it MSB-first as a 68-bit frame. Then reads back the 32-bit result and presents it on a valid/ready response port. It is the direct upstream driver of the barrel shifter slave, and its bit timing matches that slave's level-sampled SCLK behaviour.

## Interface
- SCLK_LOW_CYCLES, 1: system clocks SCLK is held low between transmit bits; legal range 1..15.
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command; high only in IDLE.
- cmd_opcode  input  4  opcode (e.g. 4'b0110 SHL, 4'b0111 SHR).
- cmd_a  input  32  operand A.
- cmd_b  input  32  operand B.
- rsp_valid  output  1  result available; held until accepted.
- rsp_ready  input  1  consumer accepts result.
- rsp_data  output  32  result word.
- busy  output  1  high from command accept until the response is accepted.
- spi  spi_if.MASTER  -  drives sclk, nss, mosi; samples miso.

## Operation
- Reset values: cmd_ready=1, rsp_valid=0, rsp_data=0, busy=0, nss=1, sclk=0, mosi=0. All internal registers and counters are cleared.
- Command capture:
  - cmd_valid && cmd_ready in IDLE latches {opcode, A, B} into a 68-bit TX register, with opcode[3] as the first bit.
  - cmd_ready drops the next cycle.
  - Inputs are ignored while not in IDLE.
- States: IDLE -> LEAD -> TX_HIGH <-> TX_LOW -> TURN -> RX_HIGH <-> RX_LOW -> RESP -> GAP -> IDLE.
- LEAD:
  - nss=0, sclk=0, mosi=bit 67.
  - Lasts max(2, SCLK_LOW_CYCLES) cycles so the slave leaves its idle state before the first edge.
- TX_HIGH: sclk=1 for exactly one cycle; mosi stable.
- TX_LOW:
  - sclk=0 for SCLK_LOW_CYCLES cycles.
  - mosi advances to the next bit on entry.
- After bit 0's TX_HIGH, go to TURN; the 7-bit bit counter runs 67 down to 0.
- TURN: sclk=1, mosi=0 for exactly 2 cycles, covering the slave's execute cycle.
- RX_HIGH:
  - sclk=1 for one cycle.
  - miso is sampled at the end of the cycle and shifted into the RX register LSB-side.
  - The first sample is result bit 31.
- RX_LOW:
  - sclk=0 for exactly one cycle, regardless of SCLK_LOW_CYCLES, because the slave shifts on every low cycle.
  - 32 RX_HIGH/RX_LOW pairs run; the 32rd RX_LOW returns the slave to idle.
- RESP:
  - nss=1, sclk=0, rsp_valid=1, rsp_data=RX register.
  - The state holds while rsp_ready=0.
  - On rsp_valid && rsp_ready, rsp_valid drops the next cycle and the state moves to GAP.
- GAP: nss=1 for 1 cycle before returning to IDLE, guaranteeing at least 2 cycles of nss high between frames.
- rsp_data keeps its value after acceptance until the next RESP.

## Timing
- With SCLK_LOW_CYCLES=1 and command accepted in cycle 0:
  - Cycles 1–2: nss low, LEAD.
  - TX_HIGH at cycles 3,5,…,137.
  - TURN at cycles 138–139.
  - RX_HIGH at cycles 140+2k and RX_LOW at 141+2k, for k=0..31.
  - nss rises and rsp_valid asserts in cycle 204.
- General frame length: lead + 68 + 67·SCLK_LOW_CYCLES + 2 + 64 cycles of nss low.
- Earliest next cmd_ready: 2 cycles after response acceptance.
- cmd_valid asserted in the same cycle as rsp acceptance: ignored; cmd_ready is 0.
- Reset mid-frame:
  - Outputs return to reset values within the same cycle, asynchronously.
  - nss=1 also resets the slave.
  - The partial result is discarded and no rsp_valid is issued.
- miso is only sampled in RX_HIGH; miso activity in any other state is ignored.

## Test plan
- SHL: opcode 0110, A=0x00000001, B=4, against a shifter slave model -> rsp_data=0x00000010 in cycle 204, 68 sclk-high cycles then 32 low pulses.
- SHR: opcode 0111, A=0x80000000, B=31 -> rsp_data=0x00000001. Also B=0x00000023 (bit 5 ignored by slave) -> 0x10000000.
- Bit order: opcode 0110, A=0xA5A5A5A5 -> mosi in TX_HIGH cycles reads 0,1,1,0 then 1,0,1,0,0,1,0,1,…; mosi is stable through each high cycle.
- Back-pressure: hold rsp_ready=0 for 20 cycles after rsp_valid -> rsp_valid and rsp_data stay stable, cmd_ready=0, and a pending cmd_valid is not accepted until 2 cycles after acceptance.
- SCLK_LOW_CYCLES=3: same SHL case -> every TX low phase is 3 cycles, RX low pulses are 1 cycle, and the result is unchanged.
- Reset in cycle 100 of a frame -> nss=1, sclk=0, rsp_valid=0 immediately. A following command completes correctly with the expected result.

Source files
------------

// File: rtl/spi_if.sv
// SPI link between the operation master and an SPI-attached functional unit.
interface spi_if;
   logic sclk;
   logic nss;
   logic mosi;
   logic miso;

   modport MASTER (output sclk, output nss, output mosi, input miso);
   modport SLAVE  (input sclk, input nss, input mosi, output miso);
endinterface

// File: rtl/spi_op_master.sv
// SPI master that ships {opcode, A, B} MSB-first to a functional-unit slave
// and returns the 32-bit result on a valid/ready response port.
module spi_op_master #(
   parameter int unsigned SCLK_LOW_CYCLES = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [3:0]  cmd_opcode,
   input  logic [31:0] cmd_a,
   input  logic [31:0] cmd_b,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic        busy,
   spi_if.MASTER       spi
);

   localparam int unsigned LEAD_CYCLES = (SCLK_LOW_CYCLES > 2) ? SCLK_LOW_CYCLES : 2;
   localparam logic [3:0]  LEAD_LOAD   = 4'(LEAD_CYCLES - 1);
   localparam logic [3:0]  LOW_LOAD    = 4'(SCLK_LOW_CYCLES - 1);

   typedef enum logic [3:0] {
      IDLE,
      LEAD,
      TX_HIGH,
      TX_LOW,
      TURN,
      RX_HIGH,
      RX_LOW,
      RESP,
      GAP
   } state_t;

   state_t      state_q, state_d;
   logic [67:0] tx_q, tx_d;
   logic [31:0] rx_q, rx_d;
   logic [6:0]  bit_q, bit_d;
   logic [3:0]  cnt_q, cnt_d;

   logic        cmd_ready_q, cmd_ready_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic [31:0] rsp_data_q, rsp_data_d;
   logic        busy_q, busy_d;
   logic        sclk_q, sclk_d;
   logic        nss_q, nss_d;
   logic        mosi_q, mosi_d;

   always_comb begin
      state_d    = state_q;
      tx_d       = tx_q;
      rx_d       = rx_q;
      bit_d      = bit_q;
      cnt_d      = cnt_q;
      rsp_data_d = rsp_data_q;

      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               tx_d    = {cmd_opcode, cmd_a, cmd_b};
               bit_d   = 7'd67;
               cnt_d   = LEAD_LOAD;
               state_d = LEAD;
            end
         end
         LEAD: begin
            if (cnt_q == 4'd0) state_d = TX_HIGH;
            else               cnt_d   = cnt_q - 4'd1;
         end
         TX_HIGH: begin
            if (bit_q == 7'd0) begin
               cnt_d   = 4'd1;
               state_d = TURN;
            end else begin
               tx_d    = {tx_q[66:0], 1'b0};
               bit_d   = bit_q - 7'd1;
               cnt_d   = LOW_LOAD;
               state_d = TX_LOW;
            end
         end
         TX_LOW: begin
            if (cnt_q == 4'd0) state_d = TX_HIGH;
            else               cnt_d   = cnt_q - 4'd1;
         end
         TURN: begin
            if (cnt_q == 4'd0) begin
               bit_d   = 7'd31;
               state_d = RX_HIGH;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RX_HIGH: begin
            rx_d    = {rx_q[30:0], spi.miso};
            state_d = RX_LOW;
         end
         RX_LOW: begin
            if (bit_q == 7'd0) begin
               rsp_data_d = rx_q;
               state_d    = RESP;
            end else begin
               bit_d   = bit_q - 7'd1;
               state_d = RX_HIGH;
            end
         end
         RESP: begin
            if (rsp_ready) state_d = GAP;
         end
         GAP:     state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Outputs are registered, so they follow the state being entered.
      cmd_ready_d = (state_d == IDLE);
      rsp_valid_d = (state_d == RESP);
      busy_d      = (state_d != IDLE) && (state_d != GAP);
      nss_d       = (state_d == IDLE) || (state_d == RESP) || (state_d == GAP);
      sclk_d      = (state_d == TX_HIGH) || (state_d == TURN) || (state_d == RX_HIGH);
      mosi_d      = ((state_d == LEAD) || (state_d == TX_HIGH) || (state_d == TX_LOW))
                    ? tx_d[67] : 1'b0;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         tx_q        <= '0;
         rx_q        <= '0;
         bit_q       <= '0;
         cnt_q       <= '0;
         cmd_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         busy_q      <= 1'b0;
         sclk_q      <= 1'b0;
         nss_q       <= 1'b1;
         mosi_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         tx_q        <= tx_d;
         rx_q        <= rx_d;
         bit_q       <= bit_d;
         cnt_q       <= cnt_d;
         cmd_ready_q <= cmd_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         busy_q      <= busy_d;
         sclk_q      <= sclk_d;
         nss_q       <= nss_d;
         mosi_q      <= mosi_d;
      end
   end

   assign cmd_ready = cmd_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign busy      = busy_q;
   assign spi.sclk  = sclk_q;
   assign spi.nss   = nss_q;
   assign spi.mosi  = mosi_q;

endmodule
